// File: rtl/mcu_bus_responder_pkg.sv
// Shared constants and address decode for the MCU bus responder.
// Region bases, FSM encodings and the read-default value live here so the top and bench agree.
package mcu_bus_responder_pkg;

  localparam logic [15:0] HRAM_BASE = 16'hFF80;
  localparam logic [15:0] IO_BASE   = 16'hFF00;
  localparam logic [15:0] IO_IF     = 16'hFF0F;
  localparam logic [15:0] IO_BOOT   = 16'hFF50;
  localparam logic [15:0] IO_IE     = 16'hFFFF;

  localparam logic [7:0] READ_DEFAULT = 8'hFF;

  localparam logic [0:0] MRSP_IDLE     = 1'b0;
  localparam logic [0:0] MRSP_EXT_WAIT = 1'b1;

  typedef enum logic [2:0] {
    REG_IE,
    REG_HRAM,
    REG_IF,
    REG_BOOT,
    REG_IO_NULL,
    REG_EXT
  } regionT;

  // Order matters: FFFF must win over the HRAM range that would otherwise contain it.
  function automatic regionT decodeRegion(input logic [15:0] addr);
    if (addr == IO_IE)          return REG_IE;
    else if (addr >= HRAM_BASE) return REG_HRAM;
    else if (addr == IO_IF)     return REG_IF;
    else if (addr == IO_BOOT)   return REG_BOOT;
    else if (addr >= IO_BASE)   return REG_IO_NULL;
    else                        return REG_EXT;
  endfunction

endpackage

// File: rtl/mcu_bus_responder_if.sv
// CPU-side bus and external fabric handshake of the MCU bus responder.
// The responder uses the slave modport; the CPU/fabric model uses master.
interface mcu_bus_responder_if;

  logic        iMCUReq;
  logic [15:0] iMCUAddr;
  logic        iMCUwe;
  logic [7:0]  iMCUData;
  logic [7:0]  oMCUData;
  logic        oBusy;
  logic        oBusErr;
  logic        oExtReq;
  logic        oExtWe;
  logic [15:0] oExtAddr;
  logic [7:0]  oExtData;
  logic        oExtBootSel;
  logic [7:0]  iExtData;
  logic        iExtAck;

  modport slave (
    input  iMCUReq, iMCUAddr, iMCUwe, iMCUData, iExtData, iExtAck,
    output oMCUData, oBusy, oBusErr, oExtReq, oExtWe, oExtAddr, oExtData, oExtBootSel
  );

  modport master (
    output iMCUReq, iMCUAddr, iMCUwe, iMCUData, iExtData, iExtAck,
    input  oMCUData, oBusy, oBusErr, oExtReq, oExtWe, oExtAddr, oExtData, oExtBootSel
  );

endinterface

// File: rtl/mcu_bus_responder_hram.sv
// 127x8 high RAM (FF80-FFFE): one write port, registered read, contents not reset.
module mcu_hram (
  input  logic       iClock,
  input  logic       iWe,
  input  logic       iRe,
  input  logic [6:0] iAddr,
  input  logic [7:0] iData,
  output logic [7:0] oData
);

  logic [7:0] mem [0:126];

  always_ff @(posedge iClock) begin
    if (iWe) mem[iAddr] <= iData;
    if (iRe) oData <= mem[iAddr];
  end

endmodule

// File: rtl/mcu_bus_responder.sv
// Slave end of the dzcpu MCU bus: serves HRAM/IF/IE/boot-disable locally, forwards the rest
// to the external fabric via req/ack with timeout, and aggregates interrupt requests.
import mcu_bus_responder_pkg::*;

module mcu_bus_responder #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 iClock,
  input  logic                 iReset,
  mcu_bus_responder_if.slave   bus,
  input  logic [4:0]           iIrqSet,
  output logic                 oIrqPending
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [0:0]  state;
  logic [7:0]  timeoutCnt;
  logic [4:0]  ifReg;
  logic [7:0]  ieReg;
  logic        overlayActive;
  logic [7:0]  rdData;
  logic        rdFromHram;
  logic [15:0] extAddr;
  logic        extWe;
  logic [7:0]  extData;
  logic        busErr;
  regionT      region;
  logic        accept;
  logic        hramWe;
  logic        hramRe;
  logic        ifWe;
  logic [7:0]  hramQ;
  logic [7:0]  ioRdData;

  assign accept = bus.iMCUReq && (state == MRSP_IDLE);
  assign region = decodeRegion(bus.iMCUAddr);
  assign hramWe = accept && (region == REG_HRAM) && bus.iMCUwe;
  assign hramRe = accept && (region == REG_HRAM) && !bus.iMCUwe;
  assign ifWe   = accept && (region == REG_IF) && bus.iMCUwe;

  mcu_hram uHram (
    .iClock (iClock),
    .iWe    (hramWe),
    .iRe    (hramRe),
    .iAddr  (bus.iMCUAddr[6:0]),
    .iData  (bus.iMCUData),
    .oData  (hramQ)
  );

  always_comb begin
    ioRdData = READ_DEFAULT;
    case (region)
      REG_IE:   ioRdData = ieReg;
      REG_IF:   ioRdData = {3'b111, ifReg};
      REG_BOOT: ioRdData = {7'h7F, overlayActive};
      default:  ioRdData = READ_DEFAULT;
    endcase
  end

  // Bus FSM: local accesses complete in IDLE, external ones park in EXT_WAIT.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state      <= MRSP_IDLE;
      timeoutCnt <= 8'h00;
      busErr     <= 1'b0;
      extAddr    <= 16'h0000;
      extWe      <= 1'b0;
      extData    <= 8'h00;
      rdData     <= 8'h00;
      rdFromHram <= 1'b0;
    end else begin
      busErr <= 1'b0;
      case (state)
        MRSP_IDLE: begin
          if (bus.iMCUReq) begin
            if (region == REG_EXT) begin
              state      <= MRSP_EXT_WAIT;
              timeoutCnt <= 8'h00;
              extAddr    <= bus.iMCUAddr;
              extWe      <= bus.iMCUwe;
              extData    <= bus.iMCUData;
            end else if (!bus.iMCUwe) begin
              // HRAM data arrives from the RAM's own output register, so just steer the mux.
              rdFromHram <= (region == REG_HRAM);
              if (region != REG_HRAM) rdData <= ioRdData;
            end
          end
        end
        default: begin
          if (bus.iExtAck) begin
            state <= MRSP_IDLE;
            if (!extWe) begin
              rdData     <= bus.iExtData;
              rdFromHram <= 1'b0;
            end
          end else if (timeoutCnt == TIMEOUT_LAST) begin
            state  <= MRSP_IDLE;
            busErr <= 1'b1;
            if (!extWe) begin
              rdData     <= READ_DEFAULT;
              rdFromHram <= 1'b0;
            end
          end else begin
            timeoutCnt <= timeoutCnt + 8'd1;
          end
        end
      endcase
    end
  end

  // Interrupt flags, enables and the one-way boot overlay latch.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      ifReg         <= 5'h00;
      ieReg         <= 8'h00;
      overlayActive <= 1'b1;
    end else begin
      ifReg <= (ifWe ? bus.iMCUData[4:0] : ifReg) | iIrqSet;
      if (accept && (region == REG_IE) && bus.iMCUwe) ieReg <= bus.iMCUData;
      if (accept && (region == REG_BOOT) && bus.iMCUwe && (bus.iMCUData != 8'h00))
        overlayActive <= 1'b0;
    end
  end

  assign bus.oMCUData    = rdFromHram ? hramQ : rdData;
  assign bus.oBusy       = (state == MRSP_EXT_WAIT);
  assign bus.oExtReq     = (state == MRSP_EXT_WAIT);
  assign bus.oBusErr     = busErr;
  assign bus.oExtWe      = extWe;
  assign bus.oExtAddr    = extAddr;
  assign bus.oExtData    = extData;
  assign bus.oExtBootSel = overlayActive && (extAddr[15:8] == 8'h00);
  assign oIrqPending     = |(ieReg[4:0] & ifReg);

endmodule
